// File: rtl/mmp_iddmm_io.sv
// Operand loader / result collector for the IDDMM Montgomery core.
// Streams m1/x/y/m words into the core's RAM write port, requests a task,
// buffers the N result words, then drains them as a backpressured stream.
module mmp_iddmm_io #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_load_m,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_data,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  input  logic              task_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_M1, S_LD_X, S_LD_Y, S_LD_M, S_REQ, S_WAIT, S_DRAIN
  } state_t;

  // Pointers are one bit wider than an address so they can hold the value N.
  localparam int                CW        = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     N_CNT     = CW'(N);
  localparam logic [CW-1:0]     LAST_CNT  = CW'(N - 1);

  state_t              state_q, state_d;
  logic                load_m_q, load_m_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [K-1:0]        m1_q, m1_d;
  logic [2:0]          wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [K-1:0]        wr_data_q, wr_data_d;
  logic                task_req_q, task_req_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                mem_we, mem_re;
  logic [ADDR_W-1:0]   mem_waddr, mem_raddr;
  logic [K-1:0]        buf_mem [N];
  logic [K-1:0]        rd_data_q;

  logic                in_hs, out_hs;

  assign in_ready = (state_q == S_LD_M1) || (state_q == S_LD_X) ||
                    (state_q == S_LD_Y)  || (state_q == S_LD_M);
  assign in_hs    = in_ready & in_valid;
  assign out_hs   = out_valid_q & out_ready;

  // Next-state, load datapath, result capture and drain control.
  always_comb begin
    state_d     = state_q;
    load_m_d    = load_m_q;
    cnt_d       = cnt_q;
    m1_d        = m1_q;
    wr_ena_d    = 3'b000;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    task_req_d  = 1'b0;
    ptr_d       = ptr_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = ptr_q[ADDR_W-1:0];
    mem_raddr   = rd_cnt_q[ADDR_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_m_d = start_load_m;
          err_d    = 1'b0;
          cnt_d    = '0;
          ptr_d    = '0;
          rd_cnt_d = '0;
          state_d  = start_load_m ? S_LD_M1 : S_LD_X;
        end
      end
      S_LD_M1: begin
        if (in_hs) begin
          m1_d    = in_data;
          state_d = S_LD_X;
        end
      end
      S_LD_X, S_LD_Y, S_LD_M: begin
        if (in_hs) begin
          wr_data_d = in_data;
          wr_addr_d = cnt_q;
          case (state_q)
            S_LD_X:  wr_ena_d = 3'b001;
            S_LD_Y:  wr_ena_d = 3'b010;
            default: wr_ena_d = 3'b100;
          endcase
          if (cnt_q == LAST_ADDR) begin
            cnt_d = '0;
            case (state_q)
              S_LD_X:  state_d = S_LD_Y;
              S_LD_Y:  state_d = load_m_q ? S_LD_M : S_REQ;
              default: state_d = S_REQ;
            endcase
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_REQ: begin
        // Registered pulse lands one cycle after the final operand write.
        task_req_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (task_grant) begin
          if (ptr_q < N_CNT) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (task_end) begin
          state_d = S_DRAIN;
          if (ptr_d != N_CNT) err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Fetch the next word whenever the output register is empty or moving.
        if (!out_valid_q || out_ready) begin
          if (rd_cnt_q < N_CNT) begin
            mem_re      = 1'b1;
            rd_cnt_d    = rd_cnt_q + CW'(1);
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == LAST_CNT);
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
        if (out_hs && out_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_m_q    <= 1'b0;
      cnt_q       <= '0;
      m1_q        <= '0;
      wr_ena_q    <= 3'b000;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      task_req_q  <= 1'b0;
      ptr_q       <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_m_q    <= load_m_d;
      cnt_q       <= cnt_d;
      m1_q        <= m1_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      task_req_q  <= task_req_d;
      ptr_q       <= ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Result buffer: block RAM with a registered, enable-gated read port.
  always_ff @(posedge clk) begin
    if (mem_we) buf_mem[mem_waddr] <= task_res;
    if (mem_re) rd_data_q <= buf_mem[mem_raddr];
  end

  assign wr_ena    = wr_ena_q;
  assign wr_addr   = wr_addr_q;
  assign wr_x      = wr_data_q;
  assign wr_y      = wr_data_q;
  assign wr_m      = wr_data_q;
  assign wr_m1     = m1_q;
  assign task_req  = task_req_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  // RAM output has no reset; masking keeps out_data at zero whenever idle.
  assign out_data  = out_valid_q ? rd_data_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_mmp_iddmm_io.sv
// Directed bench for mmp_iddmm_io with a queue-based model of the expected
// operand writes and drained results, checked on every negative clock edge.
module tb_mmp_iddmm_io;
  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, start_load_m = 1'b0, in_valid = 1'b0;
  logic [K-1:0]  in_data = '0;
  logic          in_ready;
  logic [2:0]    wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
  logic          task_req;
  logic          task_grant = 1'b0;
  logic [K-1:0]  task_res = '0;
  logic          task_end = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [K-1:0]  out_data;
  logic          out_last, busy, done, err_cnt;

  always #5 clk = ~clk;

  mmp_iddmm_io #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_load_m(start_load_m),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m),
    .wr_m1(wr_m1), .task_req(task_req), .task_grant(task_grant),
    .task_res(task_res), .task_end(task_end), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk_w(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  // Model state
  typedef struct packed {
    logic [2:0]    ena;
    logic [AW-1:0] addr;
    logic [K-1:0]  data;
  } wr_t;

  wr_t          exp_wr[$];
  int           hs_cyc[$];
  logic [K-1:0] exp_out[$];
  logic [K-1:0] mbuf [N];
  logic [K-1:0] model_m1 = '0;
  bit           skip_m1 = 1'b0;
  bit           bp_mode = 1'b0;
  bit           ov_pending = 1'b0;
  bit           stalled = 1'b0;
  logic [K-1:0] stall_data = '0;
  int           cyc = 0;
  int           last_wr_cyc = -100;
  int           te_cyc = -100;
  int           last_out_hs_cyc = -100;
  int           ena_cnt [3];
  int           n_req = 0;
  int           out_cnt = 0;
  logic [K-1:0] first_out = '0;
  logic [K-1:0] last_word = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: always high, or the 1,0,0 repeating pattern.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
  end

  // Compare process: checks every DUT output event against the model.
  initial begin : monitor
    wr_t          w;
    logic [K-1:0] e;
    int           hs;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (in_valid && in_ready) begin
          if (skip_m1) skip_m1 = 1'b0;
          else hs_cyc.push_back(cyc);
        end
        if (wr_ena != 3'b000) begin
          if (wr_ena == 3'b001) ena_cnt[0]++;
          if (wr_ena == 3'b010) ena_cnt[1]++;
          if (wr_ena == 3'b100) ena_cnt[2]++;
          if (exp_wr.size() == 0) begin
            chk_i("wr_unexpected", int'(wr_ena), 0);
          end else begin
            w  = exp_wr.pop_front();
            hs = (hs_cyc.size() > 0) ? hs_cyc.pop_front() : -100;
            chk_i("wr_ena", int'(wr_ena), int'(w.ena));
            chk_i("wr_addr", int'(wr_addr), int'(w.addr));
            chk_w("wr_x", wr_x, w.data);
            chk_w("wr_y", wr_y, w.data);
            chk_w("wr_m", wr_m, w.data);
            chk_w("wr_m1", wr_m1, model_m1);
            chk_i("wr_lag", cyc - hs, 1);
          end
          last_wr_cyc = cyc;
        end
        if (task_req) begin
          n_req++;
          chk_i("req_lag", cyc - last_wr_cyc, 1);
          chk_i("req_writes_left", exp_wr.size(), 0);
        end
        if (task_end && busy) begin
          te_cyc     = cyc;
          ov_pending = 1'b1;
        end
        if (stalled) begin
          chk_b("stall_valid", out_valid, 1'b1);
          chk_w("stall_data", out_data, stall_data);
        end
        if (out_valid && ov_pending) begin
          ov_pending = 1'b0;
          chk_i("first_out_lag", cyc - te_cyc, 2);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            chk_b("out_unexpected", out_valid, 1'b0);
          end else begin
            e = exp_out.pop_front();
            chk_w("out_data", out_data, e);
            chk_b("out_last", out_last, exp_out.size() == 0);
          end
          if (out_cnt == 0) first_out = out_data;
          if (out_last) last_word = out_data;
          out_cnt++;
          last_out_hs_cyc = cyc;
        end
        stalled = out_valid && !out_ready;
        if (stalled) stall_data = out_data;
        if (done) begin
          chk_i("done_lag", cyc - last_out_hs_cyc, 1);
          chk_i("done_words_left", exp_out.size(), 0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk_b({tag, "_in_ready"}, in_ready, 1'b0);
    chk_i({tag, "_wr_ena"}, int'(wr_ena), 0);
    chk_i({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk_w({tag, "_wr_x"}, wr_x, '0);
    chk_w({tag, "_wr_y"}, wr_y, '0);
    chk_w({tag, "_wr_m"}, wr_m, '0);
    chk_w({tag, "_wr_m1"}, wr_m1, '0);
    chk_b({tag, "_task_req"}, task_req, 1'b0);
    chk_b({tag, "_out_valid"}, out_valid, 1'b0);
    chk_w({tag, "_out_data"}, out_data, '0);
    chk_b({tag, "_out_last"}, out_last, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_err_cnt"}, err_cnt, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset(input string tag);
    #4 rst_n = 1'b0;
    #1 check_zero(tag);
    exp_wr.delete();
    hs_cyc.delete();
    exp_out.delete();
    skip_m1 = 1'b0; stalled = 1'b0; ov_pending = 1'b0; model_m1 = '0;
    in_valid = 1'b0; task_grant = 1'b0; task_end = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_load(input bit full, input logic [K-1:0] m1v, input int xoff, input int stop_after);
    logic [K-1:0] words[$];
    wr_t w;
    bit ok, r;
    for (int i = 0; i < 3; i++) ena_cnt[i] = 0;
    n_req = 0;
    out_cnt = 0;
    if (full) words.push_back(m1v);
    for (int i = 0; i < N; i++) begin
      words.push_back(K'(i + xoff));
      w.ena = 3'b001; w.addr = AW'(i); w.data = K'(i + xoff);
      exp_wr.push_back(w);
    end
    for (int i = 0; i < N; i++) begin
      words.push_back(K'(i + xoff + 'h100));
      w.ena = 3'b010; w.addr = AW'(i); w.data = K'(i + xoff + 'h100);
      exp_wr.push_back(w);
    end
    if (full) begin
      for (int i = 0; i < N; i++) begin
        words.push_back({K{1'b1}});
        w.ena = 3'b100; w.addr = AW'(i); w.data = {K{1'b1}};
        exp_wr.push_back(w);
      end
    end
    @(posedge clk);
    #2;
    if (full) begin
      skip_m1  = 1'b1;
      model_m1 = m1v;
    end
    start = 1'b1;
    start_load_m = full;
    @(posedge clk);
    #2;
    start = 1'b0;
    chk_b("busy_after_start", busy, 1'b1);
    chk_b("in_ready_after_start", in_ready, 1'b1);
    chk_b("err_clear_on_start", err_cnt, 1'b0);
    for (int k = 0; k < words.size() && k < stop_after; k++) begin
      in_valid = 1'b1;
      in_data  = words[k];
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        r = in_ready;
        @(posedge clk);
        #2;
        ok = r;
      end
      if (!ok) begin
        chk_b("in_handshake_timeout", ok, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Core stand-in: waits for task_req, emits ngr grants, then task_end.
  task automatic run_core(input int ngr, input int base);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (task_req) ok = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk_b("task_req_timeout", ok, 1'b1);
    @(posedge clk);
    #2;
    for (int i = 0; i < ngr; i++) begin
      task_grant = 1'b1;
      task_res   = K'(base + i);
      if (i < N) mbuf[i] = K'(base + i);
      @(posedge clk);
      #2;
    end
    task_grant = 1'b0;
    task_end   = 1'b1;
    @(posedge clk);
    #2;
    task_end = 1'b0;
    for (int i = 0; i < N; i++) exp_out.push_back(mbuf[i]);
  endtask

  task automatic wait_done(input logic exp_err);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge clk);
      #2;
      if (done) ok = 1'b1;
    end
    chk_b("done_timeout", ok, 1'b1);
    chk_b("err_cnt", err_cnt, exp_err);
    chk_b("idle_after_done", busy, 1'b0);
    chk_i("drained_words", out_cnt, N);
    chk_i("task_req_pulses", n_req, 1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;

    // Full load, clean result
    run_load(1'b1, K'('h5), 0, 1000);
    run_core(N, 'hA0);
    wait_done(1'b0);
    $display("txn full_load: writes %0d/%0d/%0d first %0h last %0h", ena_cnt[0], ena_cnt[1], ena_cnt[2], first_out, last_word);
    chk_i("pin_x_writes", ena_cnt[0], 32);
    chk_i("pin_y_writes", ena_cnt[1], 32);
    chk_i("pin_m_writes", ena_cnt[2], 32);
    chk_w("pin_first_out", first_out, K'('hA0));
    chk_w("pin_last_out", last_word, K'('hBF));

    // Reuse load with downstream backpressure
    bp_mode = 1'b1;
    run_load(1'b0, '0, 'h1000, 1000);
    run_core(N, 'h200);
    wait_done(1'b0);
    $display("txn reuse_bp: writes %0d/%0d/%0d last %0h", ena_cnt[0], ena_cnt[1], ena_cnt[2], last_word);
    chk_i("pin_reuse_m_writes", ena_cnt[2], 0);
    chk_i("pin_reuse_x_writes", ena_cnt[0], 32);
    chk_w("pin_reuse_m1", wr_m1, K'('h5));
    chk_w("pin_reuse_last", last_word, K'('h21F));
    bp_mode = 1'b0;

    // Short count: word 31 is left over from the previous task
    run_load(1'b1, K'('h5), 'h2000, 1000);
    run_core(N - 1, 'h300);
    wait_done(1'b1);
    $display("txn grants31: err %b last %0h", err_cnt, last_word);
    chk_w("pin_short_last", last_word, K'('h21F));

    // Overrun: 33 grants, extra word dropped
    bp_mode = 1'b1;
    run_load(1'b0, '0, 'h2800, 1000);
    run_core(N + 1, 'h400);
    wait_done(1'b1);
    $display("txn grants33: err %b last %0h", err_cnt, last_word);
    chk_w("pin_over_last", last_word, K'('h41F));
    bp_mode = 1'b0;

    // Reset mid-LD_Y
    run_load(1'b1, K'('h9), 'h3000, 1 + N + 10);
    async_reset("rst_ld_y");
    $display("txn reset_mid_load");

    // Full load, reset mid-drain
    run_load(1'b1, K'('h7), 'h3800, 1000);
    run_core(N, 'h500);
    repeat (6) @(posedge clk);
    #2;
    async_reset("rst_drain");
    $display("txn reset_mid_drain");

    // Clean full load after reset
    run_load(1'b1, K'('hB), 'h4000, 1000);
    run_core(N, 'h600);
    wait_done(1'b0);
    $display("txn post_reset: writes %0d/%0d/%0d last %0h", ena_cnt[0], ena_cnt[1], ena_cnt[2], last_word);
    chk_i("pin_post_m_writes", ena_cnt[2], 32);
    chk_w("pin_post_last", last_word, K'('h61F));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
